ex_mem_stage: RTL and testbench

Parametrised EX→MEM pipeline stage. It replaces the single-enable pipeline register with a two-entry valid/ready skid buffer, so the EX side sees a registered `in_ready` and the MEM side can stall without a combinational ready path back into EX. It adds three things the old stage lacked: synchronous flush, a per-entry writeback-enable bit, and a forwarding lookup port for the hazard unit. It sits between the EX datapath and the data-memory/MEM stage.

---
 rtl/ex_mem_pkg.sv | 20 ++
 rtl/ex_mem_stage_if.sv | 42 ++++
 rtl/pipe_skid_buf.sv | 82 ++++++++
 rtl/ex_mem_stage.sv | 62 ++++++
 tb/tb_ex_mem_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pkg.sv
// Shared widths, state encoding and payload layout for the EX->MEM pipeline stage.
package ex_mem_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned RADDR_W = 3;
  localparam int unsigned DATA_W  = 32;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0]  mem_addr;
    logic [RADDR_W-1:0] rdest_addr;
    logic [DATA_W-1:0]  rdest_data;
    logic               store;
    logic               wb_en;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bus: upstream handshake, downstream handshake, flush and forwarding lookup.
interface ex_mem_stage_if #(
  parameter int unsigned ADDR_W  = ex_mem_pkg::ADDR_W,
  parameter int unsigned RADDR_W = ex_mem_pkg::RADDR_W,
  parameter int unsigned DATA_W  = ex_mem_pkg::DATA_W
) ();
  import ex_mem_pkg::*;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [ADDR_W-1:0]  in_mem_addr;
  logic [RADDR_W-1:0] in_rdest_addr;
  logic [DATA_W-1:0]  in_rdest_data;
  logic               in_store;
  logic               in_wb_en;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_mem_addr;
  logic [RADDR_W-1:0] out_rdest_addr;
  logic [DATA_W-1:0]  out_rdest_data;
  logic               out_store;
  logic               out_wb_en;
  logic [RADDR_W-1:0] q_addr;
  logic               fwd_hit;
  logic [DATA_W-1:0]  fwd_data;

  modport master (
    output flush, in_valid, in_mem_addr, in_rdest_addr, in_rdest_data, in_store, in_wb_en,
    output out_ready, q_addr,
    input  in_ready, out_valid, out_mem_addr, out_rdest_addr, out_rdest_data, out_store,
    input  out_wb_en, fwd_hit, fwd_data
  );

  modport slave (
    input  flush, in_valid, in_mem_addr, in_rdest_addr, in_rdest_data, in_store, in_wb_en,
    input  out_ready, q_addr,
    output in_ready, out_valid, out_mem_addr, out_rdest_addr, out_rdest_data, out_store,
    output out_wb_en, fwd_hit, fwd_data
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer over an opaque payload; in_ready is decoded from state only.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         skid_valid,
  output logic [W-1:0] skid_data
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         push, pop;

  assign in_ready   = (count_q != ST_TWO);
  assign out_valid  = (count_q != ST_EMPTY);
  assign skid_valid = (count_q == ST_TWO);
  assign out_data   = main_q;
  assign skid_data  = skid_q;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush only moves the state; payload registers keep their contents.
    if (flush) begin
      count_d = ST_EMPTY;
    end else begin
      unique case (count_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = in_data;
            count_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            count_d = ST_TWO;
          end else if (pop) begin
            count_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            count_d = ST_ONE;
          end
        end
        default: count_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      count_q <= count_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: skid-buffered payload plus a youngest-first forwarding lookup.
module ex_mem_stage #(
  parameter int unsigned ADDR_W  = ex_mem_pkg::ADDR_W,
  parameter int unsigned RADDR_W = ex_mem_pkg::RADDR_W,
  parameter int unsigned DATA_W  = ex_mem_pkg::DATA_W
) (
  input logic           clk,
  input logic           resetn,
  ex_mem_stage_if.slave bus
);

  localparam int unsigned PAYLOAD_W = ADDR_W + RADDR_W + DATA_W + 2;
  localparam int unsigned DATA_LO   = 2;
  localparam int unsigned RD_LO     = DATA_LO + DATA_W;
  localparam int unsigned ADDR_LO   = RD_LO + RADDR_W;

  logic [PAYLOAD_W-1:0] in_payload, out_payload, skid_payload;
  logic                 skid_valid;
  logic                 main_match, skid_match;
  logic                 unused_skid_addr;

  assign in_payload = {bus.in_mem_addr, bus.in_rdest_addr, bus.in_rdest_data,
                       bus.in_store, bus.in_wb_en};

  pipe_skid_buf #(
    .W(PAYLOAD_W)
  ) u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (bus.flush),
    .in_valid   (bus.in_valid),
    .in_ready   (bus.in_ready),
    .in_data    (in_payload),
    .out_valid  (bus.out_valid),
    .out_ready  (bus.out_ready),
    .out_data   (out_payload),
    .skid_valid (skid_valid),
    .skid_data  (skid_payload)
  );

  assign {bus.out_mem_addr, bus.out_rdest_addr, bus.out_rdest_data,
          bus.out_store, bus.out_wb_en} = out_payload;

  // The skid entry's memory address plays no part in forwarding.
  assign unused_skid_addr = ^skid_payload[PAYLOAD_W-1:ADDR_LO];

  assign main_match = bus.out_valid & bus.out_wb_en & ~bus.out_store &
                      (bus.out_rdest_addr == bus.q_addr);
  assign skid_match = skid_valid & skid_payload[0] & ~skid_payload[1] &
                      (skid_payload[ADDR_LO-1:RD_LO] == bus.q_addr);

  always_comb begin
    bus.fwd_hit  = skid_match | main_match;
    bus.fwd_data = '0;
    if (skid_match) begin
      bus.fwd_data = skid_payload[RD_LO-1:DATA_LO];
    end else if (main_match) begin
      bus.fwd_data = bus.out_rdest_data;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage with a queue-based reference model checked every cycle.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ex_mem_stage_if bus ();

  ex_mem_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  ex_mem_payload_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: held instructions are an ordered queue, oldest first.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
    end else if (bus.flush) begin
      mq.delete();
    end else begin
      ex_mem_payload_t p;
      logic do_push;
      logic do_pop;
      do_push = bus.in_valid && (mq.size() < 2);
      do_pop  = (mq.size() > 0) && bus.out_ready;
      p = '{mem_addr: bus.in_mem_addr, rdest_addr: bus.in_rdest_addr,
            rdest_data: bus.in_rdest_data, store: bus.in_store, wb_en: bus.in_wb_en};
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(p);
    end
  end

  always @(negedge clk) begin
    if (resetn) begin
      logic            hit;
      logic [DATA_W-1:0] data;
      chk("m_in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
      chk("m_out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("m_mem_addr", 64'(bus.out_mem_addr), 64'(mq[0].mem_addr));
        chk("m_rdest_addr", 64'(bus.out_rdest_addr), 64'(mq[0].rdest_addr));
        chk("m_rdest_data", 64'(bus.out_rdest_data), 64'(mq[0].rdest_data));
        chk("m_store", 64'(bus.out_store), 64'(mq[0].store));
        chk("m_wb_en", 64'(bus.out_wb_en), 64'(mq[0].wb_en));
      end
      hit  = 1'b0;
      data = '0;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].wb_en && !mq[i].store && mq[i].rdest_addr == bus.q_addr) begin
          hit  = 1'b1;
          data = mq[i].rdest_data;
        end
      end
      chk("m_fwd_hit", 64'(bus.fwd_hit), 64'(hit));
      chk("m_fwd_data", 64'(bus.fwd_data), 64'(data));
    end
  end

  task automatic drive(input logic v, input logic [2:0] rd, input logic [31:0] d,
                       input logic st, input logic wb, input logic ordy, input logic fl);
    bus.in_valid      = v;
    bus.in_mem_addr   = 16'h1000 | 16'(d[11:0]);
    bus.in_rdest_addr = rd;
    bus.in_rdest_data = d;
    bus.in_store      = st;
    bus.in_wb_en      = wb;
    bus.out_ready     = ordy;
    bus.flush         = fl;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_drain();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.q_addr = 3'd0;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_rdest_data), 64'd0);
    chk("rst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    tick();
    resetn = 1'b1;
    tick();

    // Streaming with MEM always ready.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(i + 1), 32'hA0 + 32'(i), 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("stream_data", 64'(bus.out_rdest_data), 64'(32'hA0 + 32'(i)));
      chk("stream_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_ready", 64'(bus.in_ready), 64'd1);
    end
    idle_drain();
    tick();

    // Fill to TWO with MEM stalled, then drain in order.
    drive(1'b1, 3'd1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd2, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("drain_a", 64'(bus.out_rdest_data), 64'h11);
    tick();
    chk("drain_b", 64'(bus.out_rdest_data), 64'h22);
    chk("drain_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    // Flush in TWO with a concurrent instruction C.
    drive(1'b1, 3'd4, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd5, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd6, 32'hCC, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("flush_no_c", 64'(bus.out_valid), 64'd0);

    // Forwarding: youngest match wins, stores never forward.
    bus.q_addr = 3'd3;
    drive(1'b1, 3'd3, 32'h5, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd3, 32'h9, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fwd_two_hit", 64'(bus.fwd_hit), 64'd1);
    chk("fwd_two_data", 64'(bus.fwd_data), 64'h9);
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("fwd_main_data", 64'(bus.fwd_data), 64'h9);
    tick();
    drive(1'b1, 3'd3, 32'h7, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fwd_store_hit", 64'(bus.fwd_hit), 64'd0);
    idle_drain();
    tick();

    // A held entry without writeback enable never forwards.
    drive(1'b1, 3'd3, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fwd_nowb_hit", 64'(bus.fwd_hit), 64'd0);
    chk("fwd_nowb_data", 64'(bus.fwd_data), 64'd0);
    idle_drain();
    tick();

    // Asynchronous reset while TWO, away from any clock edge.
    drive(1'b1, 3'd3, 32'h31, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd2, 32'h32, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_addr", 64'(bus.out_mem_addr), 64'd0);
    chk("arst_out_data", 64'(bus.out_rdest_data), 64'd0);
    chk("arst_fwd_hit", 64'(bus.fwd_hit), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
